// File: rtl/store_bus_responder_if.sv
// Store bus from the core plus the buffered valid/ready output stream.
// The core/bench drives through master; the responder sits on slave.
interface store_bus_responder_if;
   logic [31:0] mem_addr;
   logic [31:0] mem_data;
   logic        mem_we;
   logic [31:0] out_data;
   logic        out_valid;
   logic        out_ready;

   modport master (
      output mem_addr, mem_data, mem_we, out_ready,
      input  out_data, out_valid
   );

   modport slave (
      input  mem_addr, mem_data, mem_we, out_ready,
      output out_data, out_valid
   );
endinterface

// File: rtl/store_bus_responder.sv
// Store-side target: data RAM, LED register and a small output FIFO in MMIO space.
// Every store is accepted in the cycle it appears; nothing back-pressures the core.
module store_bus_responder #(
   parameter int RAM_AW  = 8,
   parameter int FIFO_AW = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   store_bus_responder_if.slave bus,
   output logic [31:0]          led,
   output logic [7:0]           drop_cnt,
   input  logic [RAM_AW-1:0]    dbg_addr,
   output logic [31:0]          dbg_rdata
);
   localparam logic [31:0]      FIFO_ADDR = 32'h8000_0000;
   localparam logic [31:0]      LED_ADDR  = 32'h8000_0001;
   localparam logic [FIFO_AW:0] FIFO_FULL = (FIFO_AW + 1)'(2 ** FIFO_AW);

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   logic [31:0]        ram      [2**RAM_AW];
   logic [31:0]        fifo_mem [2**FIFO_AW];
   logic [FIFO_AW-1:0] wr_ptr;
   logic [FIFO_AW-1:0] rd_ptr;
   logic [FIFO_AW:0]   count;
   logic               ram_we;
   logic               led_we;
   logic               push_req;
   logic               pop;
   logic               push_ok;
   logic               drop;

   // A full FIFO still takes a push when the head leaves in the same cycle.
   always_comb begin
      ram_we   = bus.mem_we & ~rst & ~bus.mem_addr[31];
      led_we   = bus.mem_we & ~rst & (bus.mem_addr == LED_ADDR);
      push_req = bus.mem_we & ~rst & (bus.mem_addr == FIFO_ADDR);
      pop      = (count != '0) & bus.out_ready;
      push_ok  = push_req & ((count != FIFO_FULL) | pop);
      drop     = push_req & (count == FIFO_FULL) & ~pop;
   end

   always_ff @(posedge clk) begin
      if (ram_we) ram[bus.mem_addr[RAM_AW-1:0]] <= bus.mem_data;
   end

   always_ff @(posedge clk) begin
      if (rst) dbg_rdata <= '0;
      else     dbg_rdata <= ram[dbg_addr];
   end

   always_ff @(posedge clk) begin
      if (push_ok) fifo_mem[wr_ptr] <= bus.mem_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         drop_cnt <= '0;
         led      <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (drop)   drop_cnt <= sat_inc8(drop_cnt);
         if (led_we) led      <= bus.mem_data;
      end
   end

   assign bus.out_valid = (count != '0);
   assign bus.out_data  = fifo_mem[rd_ptr];
endmodule

// File: tb/tb_store_bus_responder.sv
// Directed bench for store_bus_responder: a vector table for decode/RAM/LED,
// then hand-written sequences for FIFO fill/drain, drop counting and reset.
module tb_store_bus_responder;
   localparam int RAM_AW  = 8;
   localparam int FIFO_AW = 2;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [31:0]       led;
   logic [7:0]        drop_cnt;
   logic [RAM_AW-1:0] dbg_addr = '0;
   logic [31:0]       dbg_rdata;

   int n_chk  = 0;
   int n_fail = 0;

   store_bus_responder_if bus ();

   store_bus_responder #(.RAM_AW(RAM_AW), .FIFO_AW(FIFO_AW)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus.slave),
      .led       (led),
      .drop_cnt  (drop_cnt),
      .dbg_addr  (dbg_addr),
      .dbg_rdata (dbg_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0]       addr;
      logic [31:0]       data;
      logic              we;
      logic [RAM_AW-1:0] dbg;
      logic [31:0]       exp_led;
      logic              chk_dbg;
      logic [31:0]       exp_dbg;
   } vec_t;

   vec_t vecs [13];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d);
      bus.mem_addr = a;
      bus.mem_data = d;
      bus.mem_we   = 1'b1;
      step();
      bus.mem_we   = 1'b0;
   endtask

   initial begin
      bus.mem_addr  = '0;
      bus.mem_data  = '0;
      bus.mem_we    = 1'b0;
      bus.out_ready = 1'b0;

      // addr, data, we, dbg_addr, led after edge, check dbg?, dbg after edge
      vecs[0]  = '{32'h0000_0005, 32'h1234_5678, 1'b1, 8'd5, 32'h0,  1'b0, 32'h0};
      vecs[1]  = '{32'h0000_0000, 32'h0,         1'b0, 8'd5, 32'h0,  1'b1, 32'h1234_5678};
      vecs[2]  = '{32'h0000_0105, 32'h0000_DEAD, 1'b1, 8'd5, 32'h0,  1'b1, 32'h1234_5678};
      vecs[3]  = '{32'h0000_0000, 32'h0,         1'b0, 8'd5, 32'h0,  1'b1, 32'h0000_DEAD};
      vecs[4]  = '{32'h0000_0007, 32'h0000_0077, 1'b1, 8'd7, 32'h0,  1'b0, 32'h0};
      vecs[5]  = '{32'h8000_0007, 32'h0000_BEEF, 1'b1, 8'd7, 32'h0,  1'b1, 32'h0000_0077};
      vecs[6]  = '{32'h0000_0000, 32'h0,         1'b0, 8'd7, 32'h0,  1'b1, 32'h0000_0077};
      vecs[7]  = '{32'h8000_0001, 32'h0000_00A5, 1'b1, 8'd5, 32'hA5, 1'b1, 32'h0000_DEAD};
      vecs[8]  = '{32'h8000_0001, 32'h0000_005A, 1'b1, 8'd5, 32'h5A, 1'b0, 32'h0};
      vecs[9]  = '{32'h8000_0001, 32'h0000_003C, 1'b1, 8'd5, 32'h3C, 1'b0, 32'h0};
      vecs[10] = '{32'h8000_0002, 32'h0000_00FF, 1'b1, 8'd5, 32'h3C, 1'b0, 32'h0};
      vecs[11] = '{32'h0000_0001, 32'h0000_FFFF, 1'b1, 8'd1, 32'h3C, 1'b0, 32'h0};
      vecs[12] = '{32'h0000_0000, 32'h0,         1'b0, 8'd1, 32'h3C, 1'b1, 32'h0000_FFFF};

      step();
      step();
      chk("reset_led", led, 32'h0);
      chk("reset_valid", {31'b0, bus.out_valid}, 32'h0);
      chk("reset_drop", {24'b0, drop_cnt}, 32'h0);
      chk("reset_dbg", dbg_rdata, 32'h0);
      rst = 1'b0;
      step();

      foreach (vecs[i]) begin
         bus.mem_addr = vecs[i].addr;
         bus.mem_data = vecs[i].data;
         bus.mem_we   = vecs[i].we;
         dbg_addr     = vecs[i].dbg;
         step();
         bus.mem_we   = 1'b0;
         chk($sformatf("vec%0d_led", i), led, vecs[i].exp_led);
         chk($sformatf("vec%0d_valid", i), {31'b0, bus.out_valid}, 32'h0);
         if (vecs[i].chk_dbg) chk($sformatf("vec%0d_dbg", i), dbg_rdata, vecs[i].exp_dbg);
      end

      // Overfill with consumer stalled: four kept, two dropped, head held.
      bus.out_ready = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         store(32'h8000_0000, k);
         chk($sformatf("fill%0d_valid", k), {31'b0, bus.out_valid}, 32'h1);
         chk($sformatf("fill%0d_head", k), bus.out_data, 32'd1);
         chk($sformatf("fill%0d_drop", k), {24'b0, drop_cnt}, (k > 4) ? k - 4 : 0);
      end
      step();
      chk("stall_head", bus.out_data, 32'd1);
      bus.out_ready = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         chk($sformatf("drain%0d_valid", k), {31'b0, bus.out_valid}, 32'h1);
         chk($sformatf("drain%0d_data", k), bus.out_data, k);
         step();
      end
      chk("drained_valid", {31'b0, bus.out_valid}, 32'h0);
      step();
      chk("empty_ready_valid", {31'b0, bus.out_valid}, 32'h0);

      // Full FIFO: push and pop in the same cycle both happen, no drop.
      bus.out_ready = 1'b0;
      for (int k = 11; k <= 14; k++) store(32'h8000_0000, k);
      bus.out_ready = 1'b1;
      store(32'h8000_0000, 32'd7);
      chk("pushpop_drop", {24'b0, drop_cnt}, 32'd2);
      chk("pushpop_head", bus.out_data, 32'd12);
      begin
         logic [31:0] exp_q [4];
         exp_q = '{32'd12, 32'd13, 32'd14, 32'd7};
         for (int k = 0; k < 4; k++) begin
            chk($sformatf("pp_drain%0d", k), bus.out_data, exp_q[k]);
            step();
         end
      end
      chk("pp_empty", {31'b0, bus.out_valid}, 32'h0);

      // Reset with entries queued; stores during reset are ignored.
      bus.out_ready = 1'b0;
      store(32'h0000_0009, 32'h0000_1111);
      store(32'h8000_0001, 32'h0000_00A5);
      chk("led_a5", led, 32'hA5);
      for (int k = 0; k < 3; k++) store(32'h8000_0000, 32'h50 + k);
      dbg_addr = 8'd5;
      rst = 1'b1;
      store(32'h0000_0009, 32'h0000_0099);
      chk("rst_led", led, 32'h0);
      chk("rst_valid", {31'b0, bus.out_valid}, 32'h0);
      chk("rst_drop", {24'b0, drop_cnt}, 32'h0);
      chk("rst_dbg", dbg_rdata, 32'h0);
      store(32'h8000_0001, 32'h0000_00FF);
      rst = 1'b0;
      dbg_addr = 8'd9;
      bus.out_ready = 1'b1;
      step();
      chk("post_rst_ram", dbg_rdata, 32'h0000_1111);
      chk("post_rst_led", led, 32'h0);
      chk("post_rst_valid", {31'b0, bus.out_valid}, 32'h0);

      // Drop counter saturation.
      bus.out_ready = 1'b0;
      for (int i = 0; i < 300; i++) begin
         store(32'h8000_0000, 32'd1000 + i);
         if (i == 257) chk("sat_254", {24'b0, drop_cnt}, 32'd254);
         if (i == 258) chk("sat_255", {24'b0, drop_cnt}, 32'd255);
      end
      chk("sat_hold", {24'b0, drop_cnt}, 32'd255);
      bus.out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("sat_drain%0d", k), bus.out_data, 32'd1000 + k);
         step();
      end
      chk("sat_empty", {31'b0, bus.out_valid}, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
